// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU sequencing controller: accumulates A, operator and B from key
// pulses, runs one req/gnt/done transaction with the ALU and shows the result.
module calc_entry_ctrl #(
    parameter int WIDTH      = 14,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_digit_vld,
    input  logic [3:0]       key_digit,
    input  logic             key_op_vld,
    input  logic [1:0]       key_op,
    input  logic             key_eq,
    input  logic             key_clr,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] disp_value,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_SHOW    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             eq_s, op_s, dig_s, dig_ok_s, dig_room_s;

    // operand*10 + digit, truncated to the operand width
    function automatic logic [WIDTH-1:0] acc_digit(input logic [WIDTH-1:0] v,
                                                   input logic [3:0] d);
        logic [WIDTH+3:0] ext;
        ext = {4'd0, v};
        ext = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, d};
        return ext[WIDTH-1:0];
    endfunction

    // Key priority resolution: clr > eq > op > digit
    always_comb begin
        eq_s       = key_eq & ~key_clr;
        op_s       = key_op_vld & ~key_eq & ~key_clr;
        dig_s      = key_digit_vld & ~key_op_vld & ~key_eq & ~key_clr;
        dig_ok_s   = dig_s & (key_digit <= 4'd9);
        dig_room_s = dig_ok_s & (cnt_q < CW'(MAX_DIGITS));
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ENTER_A;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 2'd0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            disp_q   <= '0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            disp_q   <= disp_d;
            req_q    <= req_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and operand update
    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        if (key_clr) begin
            state_d  = S_ENTER_A;
            alu_a_d  = '0;
            alu_b_d  = '0;
            alu_op_d = 2'd0;
            cnt_d    = '0;
            tmo_d    = '0;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (op_s) begin
                        alu_op_d = key_op;
                        alu_b_d  = '0;
                        cnt_d    = '0;
                        state_d  = S_ENTER_B;
                    end else if (dig_room_s) begin
                        alu_a_d = acc_digit(alu_a_q, key_digit);
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        state_d = S_ENTER_A;
                    end
                end
                S_ENTER_B: begin
                    if (eq_s) begin
                        state_d = S_ISSUE;
                    end else if (op_s) begin
                        alu_op_d = key_op;
                    end else if (dig_room_s) begin
                        alu_b_d = acc_digit(alu_b_q, key_digit);
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        state_d = S_ENTER_B;
                    end
                end
                S_ISSUE: begin
                    if (req_q && alu_gnt) begin
                        tmo_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_WAIT: begin
                    tmo_d = tmo_q + TW'(1);
                    // a done pulse on the final timeout cycle still counts
                    if (alu_done) begin
                        state_d = alu_err ? S_ERR : S_SHOW;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_SHOW: begin
                    if (eq_s) begin
                        alu_a_d = disp_q;
                        state_d = S_ISSUE;
                    end else if (op_s) begin
                        alu_a_d  = disp_q;
                        alu_op_d = key_op;
                        alu_b_d  = '0;
                        cnt_d    = '0;
                        state_d  = S_ENTER_B;
                    end else if (dig_ok_s) begin
                        alu_a_d = {{(WIDTH-4){1'b0}}, key_digit};
                        cnt_d   = CW'(1);
                        state_d = S_ENTER_A;
                    end else begin
                        state_d = S_SHOW;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ENTER_A;
                end
            endcase
        end
    end

    // Registered output values derived from the next state
    always_comb begin
        req_d  = (state_d == S_ISSUE);
        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
        err_d  = (state_d == S_ERR);
        case (state_d)
            S_ENTER_A: disp_d = alu_a_d;
            S_ENTER_B: disp_d = (cnt_d != {CW{1'b0}}) ? alu_b_d : alu_a_d;
            S_ISSUE:   disp_d = disp_q;
            S_WAIT:    disp_d = disp_q;
            S_SHOW:    disp_d = (state_q == S_WAIT) ? alu_result : disp_q;
            S_ERR:     disp_d = '0;
            default:   disp_d = '0;
        endcase
    end

    assign alu_req    = req_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign disp_value = disp_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: vector table, directed corner
// sequences and random stimulus against a behavioural calculator model.
module tb_calc_entry_ctrl;

    localparam int WIDTH   = 14;
    localparam int MAXD    = 4;
    localparam int TIMEOUT = 255;
    localparam int MOD     = 1 << WIDTH;

    localparam int M_A = 0, M_B = 1, M_I = 2, M_W = 3, M_S = 4, M_E = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_digit_vld = 1'b0;
    logic [3:0]       key_digit = 4'd0;
    logic             key_op_vld = 1'b0;
    logic [1:0]       key_op = 2'd0;
    logic             key_eq = 1'b0;
    logic             key_clr = 1'b0;
    logic             alu_gnt = 1'b0;
    logic             alu_done = 1'b0;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_err = 1'b0;
    logic             alu_req;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, disp_value;
    logic             err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model of the calculator
    int m_mode, m_a, m_b, m_op, m_disp, m_cnt, m_tmo;

    typedef struct {
        logic       dv;
        logic [3:0] d;
        logic       ov;
        logic [1:0] o;
        logic       eq, clr, gnt, done;
        logic [13:0] res;
        logic       ae;
        int         ea, eb, eop, edisp, ereq, ebusy, eerr;
    } vec_t;

    vec_t tbl[$];

    calc_entry_ctrl #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_digit_vld(key_digit_vld), .key_digit(key_digit),
        .key_op_vld(key_op_vld), .key_op(key_op),
        .key_eq(key_eq), .key_clr(key_clr),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .disp_value(disp_value), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_cnt = 0; m_tmo = 0;
    endtask

    task automatic model_step(input logic dv, input int d, input logic ov, input int o,
                              input logic eq, input logic clr, input logic gnt,
                              input logic done, input int res, input logic ae);
        bit take_digit;
        take_digit = dv && (d <= 9) && (m_cnt < MAXD);
        if (clr) begin
            model_reset();
        end else begin
            case (m_mode)
                M_A: begin
                    if (eq) begin
                    end else if (ov) begin
                        m_op = o; m_b = 0; m_cnt = 0; m_mode = M_B;
                    end else if (take_digit) begin
                        m_a = (m_a * 10 + d) % MOD; m_cnt++;
                    end
                end
                M_B: begin
                    if (eq) m_mode = M_I;
                    else if (ov) m_op = o;
                    else if (take_digit) begin
                        m_b = (m_b * 10 + d) % MOD; m_cnt++;
                    end
                end
                M_I: if (gnt) begin m_mode = M_W; m_tmo = 0; end
                M_W: begin
                    if (done) begin
                        if (ae) m_mode = M_E;
                        else begin m_disp = res; m_mode = M_S; end
                    end else begin
                        m_tmo++;
                        if (m_tmo >= TIMEOUT) m_mode = M_E;
                    end
                end
                M_S: begin
                    if (eq) begin
                        m_a = m_disp; m_mode = M_I;
                    end else if (ov) begin
                        m_a = m_disp; m_op = o; m_b = 0; m_cnt = 0; m_mode = M_B;
                    end else if (dv && d <= 9) begin
                        m_a = d; m_cnt = 1; m_mode = M_A;
                    end
                end
                default: ;
            endcase
        end
        case (m_mode)
            M_A: m_disp = m_a;
            M_B: m_disp = (m_cnt > 0) ? m_b : m_a;
            M_E: m_disp = 0;
            default: ;
        endcase
    endtask

    task automatic check_model();
        check("alu_a", int'(alu_a), m_a);
        check("alu_b", int'(alu_b), m_b);
        check("alu_op", int'(alu_op), m_op);
        check("disp_value", int'(disp_value), m_disp);
        check("alu_req", int'(alu_req), (m_mode == M_I) ? 1 : 0);
        check("busy", int'(busy), (m_mode == M_I || m_mode == M_W) ? 1 : 0);
        check("err", int'(err), (m_mode == M_E) ? 1 : 0);
    endtask

    // one clock cycle: drive at negedge, model at posedge, compare 1 time unit later
    task automatic step(input logic dv, input logic [3:0] d, input logic ov,
                        input logic [1:0] o, input logic eq, input logic clr,
                        input logic gnt, input logic done, input logic [13:0] res,
                        input logic ae);
        @(negedge clk);
        key_digit_vld = dv; key_digit = d; key_op_vld = ov; key_op = o;
        key_eq = eq; key_clr = clr; alu_gnt = gnt; alu_done = done;
        alu_result = res; alu_err = ae;
        @(posedge clk);
        model_step(dv, int'(d), ov, int'(o), eq, clr, gnt, done, int'(res), ae);
        #1;
        check_model();
        key_digit_vld = 1'b0; key_op_vld = 1'b0; key_eq = 1'b0; key_clr = 1'b0;
        alu_gnt = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    endtask

    task automatic idle();              step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic press_d(input logic [3:0] d);  step(1, d, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic press_op(input logic [1:0] o); step(0, 0, 1, o, 0, 0, 0, 0, 0, 0); endtask
    task automatic press_eq();          step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic press_clr();         step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic grant();             step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic finish_alu(input logic [13:0] r, input logic ae);
        step(0, 0, 0, 0, 0, 0, 0, 1, r, ae);
    endtask

    function automatic vec_t mk(input logic dv, input logic [3:0] d, input logic ov,
                                input logic [1:0] o, input logic eq, input logic clr,
                                input logic gnt, input logic done, input logic [13:0] res,
                                input logic ae, input int ea, input int eb, input int eop,
                                input int edisp, input int ereq, input int ebusy,
                                input int eerr);
        vec_t v;
        v.dv = dv; v.d = d; v.ov = ov; v.o = o; v.eq = eq; v.clr = clr;
        v.gnt = gnt; v.done = done; v.res = res; v.ae = ae;
        v.ea = ea; v.eb = eb; v.eop = eop; v.edisp = edisp;
        v.ereq = ereq; v.ebusy = ebusy; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        int rc;
        int n;
        //            dv d  ov o eq clr gnt dn res  ae    a     b  op disp req busy err
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,    1,    0, 0, 1,    0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0,    0,   12,    0, 0, 12,   0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,    0,  123,    0, 0, 123,  0, 0, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0,    0, 1234,    0, 0, 1234, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0,    0, 1234,    0, 0, 1234, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0,    0, 1234,    0, 2, 1234, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0,    0, 1234,    5, 2, 5,    0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 1234,    5, 2, 5,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1234,    5, 2, 5,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,    0, 1234,    5, 2, 5,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1239, 0, 1234,    5, 2, 1239, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 1, 0, 0, 0, 0, 0,    0, 1239,    0, 1, 1239, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 0,    0,    0,    0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(1, 8, 1, 3, 0, 0, 0, 0, 0,    0,    0,    0, 3, 0,    0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0,   0,    0,    0, 3, 0,    0, 0, 0));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0,    0,    0,    9, 3, 9,    0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0,    0,    0,    9, 3, 9,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,    0,    0,    9, 3, 9,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5,    1,    0,    9, 3, 0,    0, 0, 1));
        tbl.push_back(mk(1, 4, 0, 0, 1, 0, 0, 0, 0,    0,    0,    9, 3, 0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,    0,    0,    0, 0, 0,    0, 0, 0));

        model_reset();
        #12;
        check("reset_alu_req", int'(alu_req), 0);
        check("reset_disp", int'(disp_value), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table
        foreach (tbl[i]) begin
            step(tbl[i].dv, tbl[i].d, tbl[i].ov, tbl[i].o, tbl[i].eq, tbl[i].clr,
                 tbl[i].gnt, tbl[i].done, tbl[i].res, tbl[i].ae);
            check($sformatf("tbl%0d_a", i), int'(alu_a), tbl[i].ea);
            check($sformatf("tbl%0d_b", i), int'(alu_b), tbl[i].eb);
            check($sformatf("tbl%0d_op", i), int'(alu_op), tbl[i].eop);
            check($sformatf("tbl%0d_disp", i), int'(disp_value), tbl[i].edisp);
            check($sformatf("tbl%0d_req", i), int'(alu_req), tbl[i].ereq);
            check($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].ebusy);
            check($sformatf("tbl%0d_err", i), int'(err), tbl[i].eerr);
        end

        // delayed grant, then chaining and repeat
        press_d(1); press_d(2); press_op(0); press_d(3); press_d(4); press_eq();
        rc = (alu_req == 1'b1) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            idle();
            if (alu_req && alu_a == 14'd12 && alu_b == 14'd34) rc++;
        end
        check("req_hold_cycles", rc, 4);
        grant();
        check("req_drop_after_gnt", int'(alu_req), 0);
        finish_alu(14'd46, 1'b0);
        check("show_disp", int'(disp_value), 46);
        check("show_busy", int'(busy), 0);
        press_op(1); press_d(6); press_eq(); grant(); finish_alu(14'd40, 1'b0);
        check("chain_a", int'(alu_a), 46);
        check("chain_b", int'(alu_b), 6);
        check("chain_disp", int'(disp_value), 40);
        press_eq();
        check("repeat_a", int'(alu_a), 40);
        check("repeat_b", int'(alu_b), 6);
        check("repeat_req", int'(alu_req), 1);

        // lost alu_done -> timeout
        grant();
        n = 0;
        while (n < 400) begin
            idle();
            n++;
            if (err) break;
        end
        check("timeout_cycles", n, TIMEOUT);
        press_d(3); press_eq();
        check("err_hold", int'(err), 1);
        check("err_disp", int'(disp_value), 0);
        press_clr();
        check("clr_from_err_err", int'(err), 0);
        check("clr_from_err_a", int'(alu_a), 0);

        // clear during WAIT, late done ignored
        press_d(5); press_op(0); press_d(5); press_eq(); grant(); press_clr();
        finish_alu(14'd99, 1'b0);
        check("late_done_disp", int'(disp_value), 0);
        check("late_done_busy", int'(busy), 0);

        // async reset mid-ISSUE
        press_d(1); press_op(0); press_d(2); press_eq();
        check("issue_req", int'(alu_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", int'(alu_req), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_a", int'(alu_a), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 11)),
                 ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
                 14'($urandom_range(0, MOD - 1)), ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
Sequencing controller between the debounced/edge-detected keypad front end and the shared ALU. It accumulates decimal operand A, an operator, and operand B from one-cycle key pulses. It then issues a req/gnt transaction to the ALU, waits for completion, and presents the result for display. Chained operations and error recovery are handled here; the keypad path itself carries no sequencing state.

Parameters:
WIDTH, 14, operand/result width in bits (9999 fits)
MAX_DIGITS, 4, maximum decimal digits accepted per operand
TIMEOUT, 255, cycles allowed in WAIT before alu_done is declared lost

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
key_digit_vld  in  1  one-cycle pulse, digit key pressed
key_digit  in  4  digit value, valid with key_digit_vld
key_op_vld  in  1  one-cycle pulse, operator key pressed
key_op  in  2  operator code, passed through to ALU
key_eq  in  1  one-cycle pulse, equals key
key_clr  in  1  one-cycle pulse, clear key
alu_req  out  1  request to ALU, held until granted
alu_gnt  in  1  ALU accepts request this cycle
alu_op  out  2  latched operator
alu_a  out  WIDTH  operand A
alu_b  out  WIDTH  operand B
alu_done  in  1  one-cycle pulse, result valid
alu_result  in  WIDTH  ALU result, valid with alu_done
alu_err  in  1  ALU error (overflow/div0), valid with alu_done
disp_value  out  WIDTH  value for display driver
err  out  1  error state indicator
busy  out  1  high in ISSUE or WAIT

Behaviour:
- Reset: state ENTER_A. alu_a=alu_b=disp_value=0, alu_op=0, digit counter=0, alu_req=0, err=0, busy=0, timeout counter=0.
- States: ENTER_A, ENTER_B, ISSUE, WAIT, SHOW, ERR.
- Simultaneous key pulses are resolved by priority: key_clr > key_eq > key_op_vld > key_digit_vld. Only the highest one is acted on.
- key_clr in any state returns to ENTER_A with all registers at reset values. If an ALU transaction is pending, alu_req drops the next cycle and a late alu_done is ignored.
- Digit accumulation: operand <= operand*10 + key_digit, truncated to WIDTH bits, and the counter increments.
  - Digits with key_digit > 9 are ignored.
  - Digits arriving once the counter reaches MAX_DIGITS are ignored; the operand holds.
- ENTER_A:
  - Digit pulse accumulates into alu_a.
  - key_op_vld latches alu_op, clears the counter and alu_b, and moves to ENTER_B. Zero digits entered gives A=0.
  - key_eq is ignored.
- ENTER_B:
  - Digit pulse accumulates into alu_b.
  - key_op_vld replaces alu_op; B is unaffected.
  - key_eq moves to ISSUE. Zero digits entered gives B=0.
- ISSUE:
  - alu_req=1 from the first cycle in ISSUE.
  - alu_a, alu_b and alu_op stay stable while alu_req=1.
  - When alu_req=1 and alu_gnt=1 in the same cycle, go to WAIT with alu_req=0 the next cycle and the timeout counter cleared.
- WAIT:
  - Timeout counter increments each cycle.
  - alu_done with alu_err=0 captures alu_result into disp_value and moves to SHOW.
  - alu_done with alu_err=1, or the counter reaching TIMEOUT, moves to ERR.
  - alu_done arriving on the timeout cycle wins.
- SHOW:
  - Digit pulse starts a new calculation: alu_a=key_digit, counter=1, go to ENTER_A.
  - key_op_vld chains: alu_a <= result, alu_op latched, alu_b=0, counter=0, go to ENTER_B.
  - key_eq repeats the last operation with alu_a <= result and the same B and op, going to ISSUE.
- ERR: err=1 and disp_value=0. Only key_clr exits; all other keys are ignored.
- disp_value by state:
  - ENTER_A: alu_a.
  - ENTER_B: alu_b once at least one B digit is entered, otherwise alu_a.
  - ISSUE/WAIT: holds its last value.
  - SHOW: result.
- All outputs are registered; key actions are visible in outputs one cycle after the pulse.

Test Plan:
- Reset, then press 1,2,3,4,5 -> alu_a=1234 (5th digit ignored), disp_value=1234; op=2 then 5 -> disp_value=5, alu_op=2.
- A=12, op=0, B=34, eq; alu_gnt delayed 3 cycles -> alu_req high 4 cycles with a/b stable; alu_done result=46 -> SHOW, disp_value=46, busy=0.
- From SHOW (46): op=1, digit 6, eq, done result=40 -> chained alu_a=46, alu_b=6, disp_value=40; next eq -> reissue with a=40, b=6.
- WAIT with no alu_done -> ERR after exactly TIMEOUT cycles, err=1, disp_value=0; digit and eq ignored; clr -> ENTER_A, all zero.
- Same-cycle key_clr+key_digit_vld in ENTER_B -> clear wins, alu_a=0; same-cycle key_op_vld+key_digit_vld in ENTER_A -> op taken, digit dropped.
- key_clr during WAIT, then a late alu_done=1 with result 99 -> stays ENTER_A, disp_value=0; async rst_n low mid-ISSUE -> alu_req=0 immediately.
